// File: rtl/multiplicador_algoritmico_if.sv
// Request/response bundle for the multiply-accumulate unit: operands and Start in,
// registered result, range flag and Done pulse out.
interface multiplicador_algoritmico_if #(
  parameter int unsigned tamanyo = 32
);
  logic                          Start;
  logic signed [tamanyo-1:0]     Coc;
  logic signed [tamanyo-1:0]     Den;
  logic signed [tamanyo-1:0]     Res;
  logic signed [2*tamanyo-1:0]   Num;
  logic                          Fits;
  logic                          Done;

  modport master (
    output Start, Coc, Den, Res,
    input  Num, Fits, Done
  );

  modport slave (
    input  Start, Coc, Den, Res,
    output Num, Fits, Done
  );
endinterface

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed shift-and-add multiply-accumulate: Num = Coc*Den + Res.
// Sign-magnitude iteration, one ADD/SHIFT pair per multiplier bit, then a FIX step.
module multiplicador_algoritmico #(
  parameter int unsigned tamanyo = 32
) (
  input  logic                         CLK,
  input  logic                         RSTa,
  multiplicador_algoritmico_if.slave   bus
);

  localparam int unsigned W2 = 2 * tamanyo;
  localparam int unsigned CW = $clog2(tamanyo);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [tamanyo:0]   r_accu;
  logic [tamanyo-1:0] r_q;
  logic [tamanyo-1:0] r_m;
  logic [tamanyo-1:0] r_r;
  logic [CW-1:0]      r_cont;
  logic               r_sign_c;
  logic               r_sign_d;
  logic [W2-1:0]      r_num;
  logic               r_fits;
  logic               r_done;

  logic [tamanyo-1:0] w_mag_c;
  logic [tamanyo-1:0] w_mag_d;
  logic [W2-1:0]      w_prod;
  logic [W2-1:0]      w_prod_s;
  logic [W2-1:0]      w_sum;
  logic [tamanyo:0]   w_upper;
  logic               w_fits;

  // Magnitudes; |-2^(tamanyo-1)| wraps to 2^(tamanyo-1), which is correct when read unsigned
  assign w_mag_c = bus.Coc[tamanyo-1] ? tamanyo'(-bus.Coc) : tamanyo'(bus.Coc);
  assign w_mag_d = bus.Den[tamanyo-1] ? tamanyo'(-bus.Den) : tamanyo'(bus.Den);

  assign w_prod   = {r_accu[tamanyo-1:0], r_q};
  assign w_prod_s = (r_sign_c ^ r_sign_d) ? W2'(-w_prod) : w_prod;
  assign w_sum    = w_prod_s + {{tamanyo{r_r[tamanyo-1]}}, r_r};
  assign w_upper  = w_sum[W2-1:tamanyo-1];
  assign w_fits   = (&w_upper) | ~(|w_upper);

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_state_nxt = ADD;
      ADD:     w_state_nxt = SHIFT;
      SHIFT:   w_state_nxt = (r_cont == '0) ? FIX : ADD;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_accu   <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_r      <= '0;
      r_cont   <= '0;
      r_sign_c <= 1'b0;
      r_sign_d <= 1'b0;
      r_num    <= '0;
      r_fits   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_sign_c <= bus.Coc[tamanyo-1];
            r_sign_d <= bus.Den[tamanyo-1];
            r_m      <= w_mag_c;
            r_q      <= w_mag_d;
            r_r      <= bus.Res;
            r_accu   <= '0;
            r_cont   <= CW'(tamanyo - 1);
          end
        end
        ADD: begin
          if (r_q[0]) r_accu <= r_accu + {1'b0, r_m};
        end
        SHIFT: begin
          {r_accu, r_q} <= {1'b0, r_accu, r_q[tamanyo-1:1]};
          r_cont        <= r_cont - CW'(1);
        end
        FIX: begin
          r_num  <= w_sum;
          r_fits <= w_fits;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Num  = r_num;
  assign bus.Fits = r_fits;
  assign bus.Done = r_done;

endmodule
